// File: rtl/mac_half_stream_driver.sv
// Initiator-side driver for a fixed-latency half-precision MAC core (q = a*b + c),
// tracking result validity and credits; define MAC_HALF_DRV_STATS_EN to add issue/pop counters.
module mac_half_stream_driver #(
    parameter int LATENCY    = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 16
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_a,
    input  logic [DATA_W-1:0]                 s_b,
    input  logic [DATA_W-1:0]                 s_c,
    output logic [DATA_W-1:0]                 mac_a,
    output logic [DATA_W-1:0]                 mac_b,
    output logic [DATA_W-1:0]                 mac_c,
    input  logic [DATA_W-1:0]                 mac_q,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_W-1:0]                 m_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   inflight
`ifdef MAC_HALF_DRV_STATS_EN
    ,
    output logic [31:0]                       stat_issued,
    output logic [31:0]                       stat_popped
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic              issue;
    logic              pop;
    logic [CW-1:0]     credits_reg;
    logic [CW-1:0]     credits_next;
    logic              s_ready_reg;
    logic [DATA_W-1:0] mac_a_reg;
    logic [DATA_W-1:0] mac_b_reg;
    logic [DATA_W-1:0] mac_c_reg;
    logic [LATENCY-1:0] vpipe_reg;
    logic [LATENCY-1:0] vpipe_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     mem_count_reg;
    logic [CW-1:0]     mem_count_next;
    logic              push;
    logic              load;
    logic              head_valid_reg;
    logic [DATA_W-1:0] head_data_reg;

    assign issue = s_valid & s_ready_reg;
    assign pop   = head_valid_reg & m_ready;

    // Credits cover both results still in the core and results waiting in the FIFO.
    always_comb begin
        credits_next = credits_reg;
        if (issue && !pop) begin
            credits_next = credits_reg - CREDIT_ONE;
        end else if (pop && !issue) begin
            credits_next = credits_reg + CREDIT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            credits_reg <= CREDIT_MAX;
            s_ready_reg <= 1'b0;
        end else begin
            credits_reg <= credits_next;
            s_ready_reg <= (credits_next != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mac_a_reg <= '0;
            mac_b_reg <= '0;
            mac_c_reg <= '0;
        end else if (issue) begin
            mac_a_reg <= s_a;
            mac_b_reg <= s_b;
            mac_c_reg <= s_c;
        end
    end

    // The core has no valid output, so a token shifts alongside each operand set.
    assign vpipe_next[0] = issue;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vpipe
            assign vpipe_next[gi] = vpipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vpipe_reg <= '0;
        end else begin
            vpipe_reg <= vpipe_next;
        end
    end

    assign push = vpipe_reg[LATENCY-1];
    // Head refills from storage only; a result written this edge is visible a cycle later.
    assign load = (!head_valid_reg || pop) && (mem_count_reg != '0);

    always_ff @(posedge clock) begin
        if (resetn && push) begin
            mem[wr_ptr_reg] <= mac_q;
        end
    end

    always_comb begin
        mem_count_next = mem_count_reg;
        case ({push, load})
            2'b10:   mem_count_next = mem_count_reg + CREDIT_ONE;
            2'b01:   mem_count_next = mem_count_reg - CREDIT_ONE;
            default: mem_count_next = mem_count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_count_reg  <= '0;
            head_valid_reg <= 1'b0;
            head_data_reg  <= '0;
        end else begin
            mem_count_reg <= mem_count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (load) begin
                rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
                head_valid_reg <= 1'b1;
                head_data_reg  <= mem[rd_ptr_reg];
            end else if (pop) begin
                head_valid_reg <= 1'b0;
            end
        end
    end

    assign s_ready  = s_ready_reg;
    assign mac_a    = mac_a_reg;
    assign mac_b    = mac_b_reg;
    assign mac_c    = mac_c_reg;
    assign m_valid  = head_valid_reg;
    assign m_data   = head_data_reg;
    assign inflight = CREDIT_MAX - credits_reg;

`ifdef MAC_HALF_DRV_STATS_EN
    logic [31:0] stat_issued_reg;
    logic [31:0] stat_popped_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stat_issued_reg <= '0;
            stat_popped_reg <= '0;
        end else begin
            if (issue) begin
                stat_issued_reg <= stat_issued_reg + 32'd1;
            end
            if (pop) begin
                stat_popped_reg <= stat_popped_reg + 32'd1;
            end
        end
    end

    assign stat_issued = stat_issued_reg;
    assign stat_popped = stat_popped_reg;
`endif

endmodule

// File: tb/tb_mac_half_stream_driver.sv
// Bench for mac_half_stream_driver: models the MAC core, predicts results with a
// queue-based reference model, and checks outputs every cycle plus literal scenarios.
module tb_mac_half_stream_driver;

    localparam int LAT   = 9;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    logic          clock;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_a, s_b, s_c;
    logic [DW-1:0] mac_a, mac_b, mac_c, mac_q;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [4:0]    inflight;
`ifdef MAC_HALF_DRV_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_popped;
`endif

    mac_half_stream_driver #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clock(clock), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_c(s_c),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .inflight(inflight)
`ifdef MAC_HALF_DRV_STATS_EN
        , .stat_issued(stat_issued), .stat_popped(stat_popped)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Half-precision helpers: exact conversion to real, round-to-nearest-even back.
    function automatic real h2r(input logic [15:0] h);
        int  e;
        int  m;
        real r;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) r = real'(m) * (2.0 ** -24);
        else        r = (1.0 + real'(m) / 1024.0) * (2.0 ** (e - 15));
        if (h[15]) r = -r;
        return r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  a, x, frac;
        int   e, m;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a == 0.0) return {s, 15'd0};
        e = 0;
        while (a >= 2.0 ** (e + 1)) e++;
        while (a < 2.0 ** e) e--;
        if (e < -14) x = a * (2.0 ** 24);
        else         x = a / (2.0 ** (e - 10));
        m = $rtoi(x);
        frac = x - real'(m);
        if (frac > 0.5 || (frac == 0.5 && m[0])) m++;
        if (e < -14) return {s, 15'(m)};
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        if (e > 15) return {s, 5'h1f, 10'd0};
        return {s, 5'(e + 15), 10'(m - 1024)};
    endfunction

    function automatic logic [15:0] fma_h(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return r2h(h2r(a) * h2r(b) + h2r(c));
    endfunction

    function automatic logic [15:0] rand_h();
        logic [4:0] e;
        e = 5'($urandom_range(20, 10));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    // Core model: fixed-latency pipe that ignores handshakes and reset.
    logic [DW-1:0] core_pipe [LAT-1];
    always @(posedge clock) begin
        core_pipe[0] <= fma_h(mac_a, mac_b, mac_c);
        for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign mac_q = core_pipe[LAT-2];

    // Reference model: results become visible LAT+1 edges after their handshake.
    typedef struct {
        logic [15:0] v;
        int          t;
    } res_t;
    res_t exp_q[$];
    int   inflight_m = 0;
    int   issued_m = 0;
    int   popped_m = 0;
    bit   after_rst = 1'b0;
    bit   armed = 1'b0;
    bit   mv_exp;
    bit   sr_exp;

    always @(negedge clock) begin
        mv_exp = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
        sr_exp = !after_rst && (inflight_m < DEPTH);
        if (armed) begin
            chk("inflight", 32'(inflight), 32'(inflight_m));
            chk("s_ready", 32'(s_ready), 32'(sr_exp));
            chk("m_valid", 32'(m_valid), 32'(mv_exp));
            if (mv_exp) chk("m_data", 32'(m_data), 32'(exp_q[0].v));
            if (after_rst) begin
                chk("rst_m_data", 32'(m_data), 32'd0);
                chk("rst_mac_abc", {8'd0, 8'(mac_a | mac_b), 16'(mac_c)}, 32'd0);
            end
`ifdef MAC_HALF_DRV_STATS_EN
            chk("stat_issued", stat_issued, 32'(issued_m));
            chk("stat_popped", stat_popped, 32'(popped_m));
            chk("stat_diff", stat_issued - stat_popped, 32'(inflight_m));
`endif
        end
        if (!resetn) begin
            exp_q.delete();
            inflight_m = 0;
            issued_m = 0;
            popped_m = 0;
            after_rst = 1'b1;
            armed = 1'b1;
        end else if (armed) begin
            if (mv_exp && m_ready) begin
                $display("[%0d] pop result %h", cyc + 1, exp_q[0].v);
                void'(exp_q.pop_front());
                inflight_m--;
                popped_m++;
            end
            if (s_valid && sr_exp) begin
                exp_q.push_back('{fma_h(s_a, s_b, s_c), cyc + 1 + LAT + 1});
                inflight_m++;
                issued_m++;
            end
            after_rst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        for (int k = 0; k < 1000 && cyc < t; k++) tick();
    endtask

    task automatic rand_ops();
        s_a = rand_h();
        s_b = rand_h();
        s_c = rand_h();
    endtask

    int n;
    int cnt;
    int peak;

    initial begin
        resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_a = '0; s_b = '0; s_c = '0;
        chk("pin_model_3", 32'(fma_h(16'h3C00, 16'h4000, 16'h3C00)), 32'h4200);
        chk("pin_model_5", 32'(fma_h(16'h4000, 16'h4000, 16'h3C00)), 32'h4500);
        chk("pin_model_0", 32'(fma_h(16'hC000, 16'h3800, 16'h3C00)), 32'h0000);
        repeat (3) tick();
        chk("reset_s_ready", 32'(s_ready), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        resetn = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("sready_after_release", 32'(s_ready), 32'd1);

        // Single op: 1*2+1 = 3
        s_a = 16'h3C00; s_b = 16'h4000; s_c = 16'h3C00; s_valid = 1'b1;
        n = cyc + 1;
        tick();
        s_valid = 1'b0;
        wait_cyc(n + LAT);
        chk("single_early", 32'(m_valid), 32'd0);
        tick();
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data", 32'(m_data), 32'h4200);
        tick();
        chk("single_once", 32'(m_valid), 32'd0);

        // Streaming
        peak = 0;
        for (int i = 0; i < 64; i++) begin
            rand_ops();
            s_valid = 1'b1;
            chk("stream_s_ready", 32'(s_ready), 32'd1);
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
        end
        s_valid = 1'b0;
        repeat (20) tick();
        $display("streaming peak inflight %0d", peak);

        // Backpressure
        m_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            s_valid = 1'b1;
            if (s_ready) cnt++;
            tick();
        end
        chk("bp_issue_count", 32'(cnt), 32'd16);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_inflight", 32'(inflight), 32'd16);

        // Credit boundary: pop with s_valid held at zero credits
        rand_ops();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("cb_sready_after_pop", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("cb_inflight", 32'(inflight), 32'd16);
        chk("cb_s_ready_low", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        repeat (30) tick();

        // Reset mid-flight: 5 issued, 3 already in the FIFO
        m_ready = 1'b0;
        n = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        wait_cyc(n + LAT + 2);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_inflight", 32'(inflight), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_stale", 32'(m_valid), 32'd0);
        end
        s_a = 16'h4000; s_b = 16'h4000; s_c = 16'h3C00; s_valid = 1'b1;
        n = cyc + 1;
        tick();
        s_valid = 1'b0;
        wait_cyc(n + LAT + 1);
        chk("fresh_valid", 32'(m_valid), 32'd1);
        chk("fresh_data", 32'(m_data), 32'h4500);

        // Random traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            rand_ops();
            s_valid = ($urandom_range(3, 0) != 0);
            m_ready = ($urandom_range(2, 0) != 0);
            resetn  = ($urandom_range(149, 0) != 0);
            tick();
        end
        resetn = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (30) tick();
        chk("drain_inflight", 32'(inflight), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
